// File: rtl/dsp_mac_pkg.sv
// Shared constants and types for the DSP MAC sequencer.
//   - Operand, product and accumulator widths of the DSP slice datapath.
//   - Opmode encodings driven to the slice (X mux in [1:0], Z mux in [3:2]).
//   - Sequencer FSM state enum and the operand-pair payload struct.
package dsp_mac_pkg;

   localparam int unsigned A_W    = 18;
   localparam int unsigned B_W    = 18;
   localparam int unsigned M_W    = 36;
   localparam int unsigned P_W    = 48;
   localparam int unsigned OPM_W  = 8;
   localparam int unsigned FCNT_W = 16;

   // X=M, Z=0: start a new accumulation from the product alone
   localparam logic [OPM_W-1:0] OPM_CLEAR = 8'h01;
   // X=M, Z=P: add the product to the running accumulator
   localparam logic [OPM_W-1:0] OPM_ACC   = 8'h09;
   // X=0, Z=P: accumulator holds its value
   localparam logic [OPM_W-1:0] OPM_HOLD  = 8'h08;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic [A_W-1:0] a;
      logic [B_W-1:0] b;
   } term_t;

endpackage

// File: rtl/dsp_mac_sequencer_opmode_delay.sv
// opmode_delay: DEPTH-stage 8-bit shift register that re-times the opmode
// stream so it lines up with the slice's operand pipeline.
//   CLK, RSTN : clock, asynchronous active-low reset (all stages clear to 8'h00)
//   opm_i     : opmode for the current issue slot
//   opm_o     : opmode delayed by DEPTH edges (pass-through when DEPTH == 0)
module opmode_delay
   import dsp_mac_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic [OPM_W-1:0] opm_i,
   output logic [OPM_W-1:0] opm_o
);

   if (DEPTH == 0) begin : g_bypass
      // Clock and reset are not needed without stages.
      logic unused_clk_rst;
      assign unused_clk_rst = CLK ^ RSTN;
      assign opm_o          = opm_i;
   end else begin : g_shift
      localparam int unsigned LINE_W = DEPTH * OPM_W;

      logic [LINE_W-1:0] line_q;
      logic [LINE_W-1:0] line_d;

      // New slot enters at the low byte, oldest byte falls off the top.
      always_comb begin
         line_d = LINE_W'({line_q, opm_i});
      end

      always_ff @(posedge CLK or negedge RSTN) begin
         if (!RSTN) begin
            line_q <= '0;
         end else begin
            line_q <= line_d;
         end
      end

      assign opm_o = line_q[LINE_W-1 -: OPM_W];
   end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: feeds (A, B) operand pairs into a DSP48A1-style slice,
// drives a pipeline-aligned opmode, and captures the slice P output once per
// frame of N_TAPS terms.
//   CLK, RSTN              : clock, asynchronous active-low reset
//   in_valid/in_ready      : operand-pair handshake (in_ready is state-only)
//   in_a, in_b             : unsigned 18-bit operands
//   dsp_a, dsp_b           : registered operands to the slice
//   dsp_opmode             : per-slot opmode delayed by OP_DELAY edges
//   dsp_p                  : slice accumulator output
//   out_valid/out_ready    : result handshake
//   out_data               : captured accumulated result (held until next capture)
//   frame_cnt              : handshake counter, present only with
//                            MAC_SEQ_FRAME_CNT_EN defined
module dsp_mac_sequencer
   import dsp_mac_pkg::*;
#(
   parameter int unsigned N_TAPS   = 8,
   parameter int unsigned OP_DELAY = 1,
   parameter int unsigned P_LAT    = 3
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [A_W-1:0]    in_a,
   input  logic [B_W-1:0]    in_b,
   output logic [A_W-1:0]    dsp_a,
   output logic [B_W-1:0]    dsp_b,
   output logic [OPM_W-1:0]  dsp_opmode,
   input  logic [P_W-1:0]    dsp_p,
   output logic              out_valid,
   input  logic              out_ready,
`ifdef MAC_SEQ_FRAME_CNT_EN
   output logic [FCNT_W-1:0] frame_cnt,
`endif
   output logic [P_W-1:0]    out_data
);

   localparam int unsigned CNT_W   = $clog2(N_TAPS + 1);
   localparam int unsigned DRAIN_W = $clog2(P_LAT + 1);

   state_e              state_q,     state_d;
   logic [CNT_W-1:0]    term_cnt_q,  term_cnt_d;
   logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
   term_t               pair_q,      pair_d;
   logic [OPM_W-1:0]    opm_q,       opm_d;
   logic                in_ready_q,  in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic [P_W-1:0]      out_data_q,  out_data_d;
`ifdef MAC_SEQ_FRAME_CNT_EN
   logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
`endif

   logic accept;

   // Next-state and issue logic; every slot that is not a term issues HOLD.
   always_comb begin
      state_d     = state_q;
      term_cnt_d  = term_cnt_q;
      drain_cnt_d = drain_cnt_q;
      pair_d      = pair_q;
      opm_d       = OPM_HOLD;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      accept      = in_valid && in_ready_q;
`ifdef MAC_SEQ_FRAME_CNT_EN
      frame_cnt_d = frame_cnt_q + FCNT_W'(out_valid_q && out_ready);
`endif

      unique case (state_q)
         IDLE: begin
            drain_cnt_d = '0;
            if (accept) begin
               pair_d.a   = in_a;
               pair_d.b   = in_b;
               opm_d      = OPM_CLEAR;
               term_cnt_d = CNT_W'(1);
               if (N_TAPS == 1) begin
                  state_d = DRAIN;
               end else begin
                  state_d = ACCUM;
               end
            end
         end
         ACCUM: begin
            drain_cnt_d = '0;
            if (accept) begin
               pair_d.a   = in_a;
               pair_d.b   = in_b;
               opm_d      = OPM_ACC;
               term_cnt_d = term_cnt_q + CNT_W'(1);
               if (term_cnt_d == CNT_W'(N_TAPS)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // P reflects the last term P_LAT edges after its issue; sample one edge later.
            if (drain_cnt_q == DRAIN_W'(P_LAT)) begin
               out_data_d  = dsp_p;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               term_cnt_d  = '0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Registered Moore ready: decoded from the next state.
      in_ready_d = (state_d == IDLE) || (state_d == ACCUM);
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= IDLE;
         term_cnt_q  <= '0;
         drain_cnt_q <= '0;
         pair_q      <= '0;
         opm_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
`ifdef MAC_SEQ_FRAME_CNT_EN
         frame_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         term_cnt_q  <= term_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         pair_q      <= pair_d;
         opm_q       <= opm_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
`ifdef MAC_SEQ_FRAME_CNT_EN
         frame_cnt_q <= frame_cnt_d;
`endif
      end
   end

   // Opmode leaves the issue register aligned with dsp_a/dsp_b, then is re-timed.
   opmode_delay #(
      .DEPTH (OP_DELAY)
   ) u_opmode_delay (
      .CLK   (CLK),
      .RSTN  (RSTN),
      .opm_i (opm_q),
      .opm_o (dsp_opmode)
   );

   assign in_ready  = in_ready_q;
   assign dsp_a     = pair_q.a;
   assign dsp_b     = pair_q.b;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
`ifdef MAC_SEQ_FRAME_CNT_EN
   assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench for dsp_mac_sequencer with N_TAPS=4, OP_DELAY=1, P_LAT=3.
// Contains a cycle model of the DSP slice (A/B reg, M reg, opmode reg, P reg)
// and a frame-level reference model of the sequencer's observable behaviour.
// Honors MAC_SEQ_FRAME_CNT_EN when defined.
module tb_dsp_mac_sequencer;
   import dsp_mac_pkg::*;

   localparam int unsigned N_TAPS   = 4;
   localparam int unsigned OP_DELAY = 1;
   localparam int unsigned P_LAT    = 3;

   logic              CLK = 1'b0;
   logic              RSTN;
   logic              in_valid;
   logic              in_ready;
   logic [A_W-1:0]    in_a;
   logic [B_W-1:0]    in_b;
   logic [A_W-1:0]    dsp_a;
   logic [B_W-1:0]    dsp_b;
   logic [OPM_W-1:0]  dsp_opmode;
   logic [P_W-1:0]    dsp_p;
   logic              out_valid;
   logic              out_ready;
   logic [P_W-1:0]    out_data;
`ifdef MAC_SEQ_FRAME_CNT_EN
   logic [FCNT_W-1:0] frame_cnt;
`endif

   int vectors       = 0;
   int errors        = 0;
   int edge_no       = 0;
   int last_acc_edge = 0;
   bit chk_en        = 1'b0;

   dsp_mac_sequencer #(
      .N_TAPS   (N_TAPS),
      .OP_DELAY (OP_DELAY),
      .P_LAT    (P_LAT)
   ) dut (
      .CLK        (CLK),
      .RSTN       (RSTN),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .dsp_a      (dsp_a),
      .dsp_b      (dsp_b),
      .dsp_opmode (dsp_opmode),
      .dsp_p      (dsp_p),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
`ifdef MAC_SEQ_FRAME_CNT_EN
      .frame_cnt  (frame_cnt),
`endif
      .out_data   (out_data)
   );

   always #5 CLK = ~CLK;

   // ---------------- DSP slice model ----------------
   logic [A_W-1:0]   sl_a   = '0;
   logic [B_W-1:0]   sl_b   = '0;
   logic [M_W-1:0]   sl_m   = '0;
   logic [OPM_W-1:0] sl_opm = '0;
   logic [P_W-1:0]   sl_p   = '0;

   always @(posedge CLK) begin
      sl_a   <= dsp_a;
      sl_b   <= dsp_b;
      sl_m   <= M_W'(sl_a) * M_W'(sl_b);
      sl_opm <= dsp_opmode;
      sl_p   <= ((sl_opm[3:2] == 2'b10) ? sl_p : P_W'(0)) +
                ((sl_opm[1:0] == 2'b01) ? P_W'(sl_m) : P_W'(0));
   end
   assign dsp_p = sl_p;

   // ---------------- comparison helper ----------------
   task automatic chk(input string name, input logic [P_W-1:0] act, input logic [P_W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d, t=%0t)", name, act, exp, edge_no, $time);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   logic              m_ready     = 1'b1;
   logic              m_out_valid = 1'b0;
   logic [P_W-1:0]    m_out_data  = '0;
   logic [P_W-1:0]    m_sum       = '0;
   logic [A_W-1:0]    m_a         = '0;
   logic [B_W-1:0]    m_b         = '0;
   logic [FCNT_W-1:0] m_frames    = '0;
   int                m_terms     = 0;
   int                m_countdown = 0;
   logic [OPM_W-1:0]  m_hist [OP_DELAY+1] = '{default: '0};

   always @(posedge CLK or negedge RSTN) begin
      logic [OPM_W-1:0] slot;
      if (!RSTN) begin
         m_ready     = 1'b1;
         m_out_valid = 1'b0;
         m_out_data  = '0;
         m_sum       = '0;
         m_a         = '0;
         m_b         = '0;
         m_frames    = '0;
         m_terms     = 0;
         m_countdown = 0;
         for (int i = 0; i <= OP_DELAY; i++) m_hist[i] = '0;
      end else begin
         edge_no++;
         slot = OPM_HOLD;
         if (m_out_valid) begin
            if (out_ready) begin
               m_out_valid = 1'b0;
               m_ready     = 1'b1;
               m_frames    = m_frames + 1'b1;
            end
         end else if (m_countdown > 0) begin
            m_countdown--;
            if (m_countdown == 0) begin
               m_out_valid = 1'b1;
               m_out_data  = m_sum;
            end
         end else if (in_valid && m_ready) begin
            slot  = (m_terms == 0) ? OPM_CLEAR : OPM_ACC;
            m_sum = ((m_terms == 0) ? P_W'(0) : m_sum) + P_W'(in_a) * P_W'(in_b);
            m_a   = in_a;
            m_b   = in_b;
            m_terms++;
            if (m_terms == N_TAPS) begin
               m_terms     = 0;
               m_ready     = 1'b0;
               m_countdown = P_LAT + 1;
            end
         end
         for (int i = OP_DELAY; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = slot;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge CLK) begin
      if (chk_en) begin
         chk("in_ready",   P_W'(in_ready),   P_W'(m_ready));
         chk("out_valid",  P_W'(out_valid),  P_W'(m_out_valid));
         chk("out_data",   out_data,         m_out_data);
         chk("dsp_a",      P_W'(dsp_a),      P_W'(m_a));
         chk("dsp_b",      P_W'(dsp_b),      P_W'(m_b));
         chk("dsp_opmode", P_W'(dsp_opmode), P_W'(m_hist[OP_DELAY]));
`ifdef MAC_SEQ_FRAME_CNT_EN
         chk("frame_cnt",  P_W'(frame_cnt),  P_W'(m_frames));
`endif
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid  = 1'b0;
         in_a      = A_W'($urandom);
         in_b      = B_W'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         @(posedge CLK); #1;
      end
      out_ready = 1'b0;
   endtask

   task automatic send_term(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
      logic rdy;
      bit   done   = 1'b0;
      int   budget = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      while (!done) begin
         rdy = in_ready;
         @(posedge CLK); #1;
         if (rdy) begin
            done = 1'b1;
         end else if (++budget > 64) begin
            chk("accept_timeout", P_W'(in_ready), P_W'(1));
            done = 1'b1;
         end
      end
      last_acc_edge = edge_no;
   endtask

   task automatic get_result(input int hold, output logic [P_W-1:0] data, output int lat);
      int budget = 0;
      bit ok     = 1'b1;
      out_ready  = 1'b0;
      while (!out_valid && ok) begin
         in_valid = 1'($urandom_range(0, 1));
         in_a     = A_W'($urandom);
         in_b     = B_W'($urandom);
         @(posedge CLK); #1;
         if (++budget > 50) begin
            chk("result_timeout", P_W'(out_valid), P_W'(1));
            ok = 1'b0;
         end
      end
      lat  = edge_no - last_acc_edge;
      data = out_data;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         @(posedge CLK); #1;
      end
      if (hold > 0) begin
         chk("hold_out_valid", P_W'(out_valid), P_W'(1));
         chk("hold_in_ready",  P_W'(in_ready),  P_W'(0));
      end
      out_ready = 1'b1;
      @(posedge CLK); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
   endtask

   // ---------------- scenario sequence ----------------
   initial begin
      logic [P_W-1:0] res;
      int             lat;
      logic [A_W-1:0] ra;
      logic [B_W-1:0] rb;

      RSTN      = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk_en = 1'b1;

      chk("rst_in_ready",  P_W'(in_ready),   P_W'(1));
      chk("rst_out_valid", P_W'(out_valid),  P_W'(0));
      chk("rst_out_data",  out_data,         P_W'(0));
      chk("rst_dsp_a",     P_W'(dsp_a),      P_W'(0));
      chk("rst_opmode",    P_W'(dsp_opmode), P_W'(0));
      RSTN = 1'b1;
      idle(2);

      // Back-to-back frame: 2+12+30+56
      send_term(18'd1, 18'd2);
      send_term(18'd3, 18'd4);
      send_term(18'd5, 18'd6);
      send_term(18'd7, 18'd8);
      get_result(0, res, lat);
      chk("f1_data",    res,       P_W'(100));
      chk("f1_latency", P_W'(lat), P_W'(4));

      // Second frame must not carry over the previous accumulation
      idle(1);
      repeat (4) send_term(18'd1, 18'd1);
      get_result(0, res, lat);
      chk("f2_data", res, P_W'(4));

      // Bubbles between terms
      send_term(18'd1, 18'd2); idle(2);
      send_term(18'd3, 18'd4); idle(2);
      send_term(18'd5, 18'd6); idle(2);
      send_term(18'd7, 18'd8);
      get_result(0, res, lat);
      chk("bubble_data",    res,       P_W'(100));
      chk("bubble_latency", P_W'(lat), P_W'(4));

      // Full-scale operands, result held 10 cycles before consumption
      repeat (4) send_term(18'h3FFFF, 18'h3FFFF);
      get_result(10, res, lat);
      chk("max_data", res, 48'h003F_FFE0_0004);

      // Reset in the middle of a frame
      send_term(18'd9, 18'd9);
      send_term(18'd10, 18'd10);
      in_valid = 1'b0;
      RSTN     = 1'b0;
      #1;
      chk("midrst_in_ready",  P_W'(in_ready),   P_W'(1));
      chk("midrst_out_data",  out_data,         P_W'(0));
      chk("midrst_dsp_a",     P_W'(dsp_a),      P_W'(0));
      chk("midrst_dsp_b",     P_W'(dsp_b),      P_W'(0));
      chk("midrst_opmode",    P_W'(dsp_opmode), P_W'(0));
`ifdef MAC_SEQ_FRAME_CNT_EN
      chk("midrst_frame_cnt", P_W'(frame_cnt),  P_W'(0));
`endif
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RSTN = 1'b1;
      repeat (4) send_term(18'd2, 18'd3);
      get_result(0, res, lat);
      chk("postrst_data", res, P_W'(24));
`ifdef MAC_SEQ_FRAME_CNT_EN
      chk("postrst_frame_cnt", P_W'(frame_cnt), P_W'(1));
`endif

      // Randomized frames with random bubbles and back-pressure
      for (int f = 0; f < 40; f++) begin
         for (int t = 0; t < N_TAPS; t++) begin
            ra = ($urandom_range(0, 7) == 0) ? 18'h3FFFF : A_W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 18'h3FFFF : B_W'($urandom);
            send_term(ra, rb);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
         end
         get_result(int'($urandom_range(0, 6)), res, lat);
         chk("rand_latency", P_W'(lat), P_W'(P_LAT + 1));
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
      end

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   // Absolute time limit so the run always terminates.
   initial begin
      #200000;
      chk("global_timeout", P_W'(chk_en), P_W'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $fatal(1, "time limit reached");
   end

endmodule
